// File: rtl/dwell_driver.sv
// Relay/switch driver that enforces a minimum dwell after every output change.
// Requests arriving while the output is settling are ignored. A mismatch is picked up one enabled clock after settled rises.
module dwell_driver #(
    parameter int settle_count = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic ce_n,
    input  logic req_in,
    output logic drive_out,
    output logic drive_outn,
    output logic settled
);

    // Number of bits needed to hold value (at least 1 for value >= 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        for (r = 0; v > 0; r++) v = v >> 1;
        return r;
    endfunction

    localparam int            CW   = clogb2(settle_count - 1);
    localparam logic [CW-1:0] LOAD = CW'(settle_count - 1);

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        ON_SETTLE  = 2'd1,
        ON         = 2'd2,
        OFF_SETTLE = 2'd3
    } state_t;

    // Declaration values match the reset values so power-up equals reset.
    state_t        state_q   = OFF;
    logic [CW-1:0] cnt_q     = '0;
    logic          drive_q   = 1'b0;
    logic          settled_q = 1'b1;

    state_t        state_d;
    logic [CW-1:0] cnt_d;
    logic          drive_d;
    logic          settled_d;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            drive_q   <= 1'b0;
            settled_q <= 1'b1;
        end else if (!ce_n) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drive_q   <= drive_d;
            settled_q <= settled_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drive_d   = drive_q;
        settled_d = settled_q;
        case (state_q)
            OFF: begin
                if (req_in) begin
                    state_d   = ON_SETTLE;
                    drive_d   = 1'b1;
                    settled_d = 1'b0;
                    cnt_d     = LOAD;
                end
            end
            ON: begin
                if (!req_in) begin
                    state_d   = OFF_SETTLE;
                    drive_d   = 1'b0;
                    settled_d = 1'b0;
                    cnt_d     = LOAD;
                end
            end
            ON_SETTLE, OFF_SETTLE: begin
                // req_in is deliberately not looked at while settling.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d   = (state_q == ON_SETTLE) ? ON : OFF;
                    settled_d = 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
    end

    assign drive_out  = drive_q;
    assign drive_outn = ~drive_q;
    assign settled    = settled_q;

endmodule

// File: tb/tb_dwell_driver.sv
// Bench for dwell_driver: scoreboarded small-count instance plus a default-count instance.
module tb_dwell_driver;
    localparam int SC  = 4;
    localparam int SCB = 1024;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn = 1'b0, ce_n = 1'b0, req_in = 1'b0;
    logic drive_out, drive_outn, settled;
    logic b_aresetn = 1'b1, b_ce_n = 1'b0, b_req = 1'b0;
    logic b_drive_out, b_drive_outn, b_settled;

    dwell_driver #(.settle_count(SC)) dut (
        .aclk(aclk), .aresetn(aresetn), .ce_n(ce_n), .req_in(req_in),
        .drive_out(drive_out), .drive_outn(drive_outn), .settled(settled)
    );

    dwell_driver #(.settle_count(SCB)) dut_big (
        .aclk(aclk), .aresetn(b_aresetn), .ce_n(b_ce_n), .req_in(b_req),
        .drive_out(b_drive_out), .drive_outn(b_drive_outn), .settled(b_settled)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [2:0] exp_q[$];
    logic m_drive = 1'b0;
    logic m_settled = 1'b1;
    int   m_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one clock of stimulus, predict the result, then compare at posedge+1.
    task automatic step(input logic rst, input logic ce, input logic req);
        logic [2:0] prev;
        logic [2:0] e;
        @(negedge aclk);
        prev    = {drive_out, drive_outn, settled};
        aresetn = rst;
        ce_n    = ~ce;
        req_in  = req;
        if (!rst) begin
            m_drive = 1'b0; m_settled = 1'b1; m_left = 0;
        end else if (ce) begin
            if (m_settled) begin
                if (req != m_drive) begin
                    m_drive = req; m_settled = 1'b0; m_left = SC;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_settled = 1'b1;
            end
        end
        exp_q.push_back({m_drive, ~m_drive, m_settled});
        @(posedge aclk);
        #1;
        e = exp_q.pop_front();
        chk("sb_out", {29'd0, drive_out, drive_outn, settled}, {29'd0, e});
        if (rst && !ce) chk("ce_hold", {29'd0, drive_out, drive_outn, settled}, {29'd0, prev});
    endtask

    // Step until settled, counting additional low samples into n.
    task automatic wait_settled(input logic req, inout int n);
        for (int k = 0; k < 40 && settled !== 1'b1; k++) begin
            step(1'b1, 1'b1, req);
            if (settled !== 1'b1) n++;
        end
        chk("settle_reached", {31'd0, settled}, 32'd1);
    endtask

    initial begin
        int n;
        int nh;
        logic inv_ok;
        #1;
        chk("pwrup", {29'd0, drive_out, drive_outn, settled}, 32'b011);
        chk("pwrup_big", {29'd0, b_drive_out, b_drive_outn, b_settled}, 32'b011);

        // Reset held with req high, then release.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("rst_out", {29'd0, drive_out, drive_outn, settled}, 32'b011);
        step(1'b1, 1'b1, 1'b1);
        chk("rel_drive", {31'd0, drive_out}, 32'd1);
        n = (settled === 1'b0) ? 1 : 0;
        wait_settled(1'b1, n);
        chk("rel_len", n, SC);

        // Back to OFF, then a one-clock request pulse.
        step(1'b1, 1'b1, 1'b0);
        n = 0;
        wait_settled(1'b0, n);
        step(1'b1, 1'b1, 1'b1);
        nh = (drive_out === 1'b1) ? 1 : 0;
        for (int k = 0; k < 40 && drive_out === 1'b1; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (drive_out === 1'b1) nh++;
        end
        chk("pulse_high", nh, SC + 1);
        n = (settled === 1'b0) ? 1 : 0;
        wait_settled(1'b0, n);
        chk("pulse_off_len", n, SC);

        // req toggling every clock throughout ON_SETTLE.
        step(1'b1, 1'b1, 1'b1);
        n = 1;
        for (int k = 0; k < 40 && settled !== 1'b1; k++) begin
            step(1'b1, 1'b1, (k % 2) == 1);
            chk("tog_drive", {31'd0, drive_out}, 32'd1);
            if (settled !== 1'b1) n++;
        end
        chk("tog_len", n, SC);
        step(1'b1, 1'b1, 1'b0);
        n = 0;
        wait_settled(1'b0, n);

        // Clock enable low on alternate clocks during a dwell.
        step(1'b1, 1'b1, 1'b1);
        n = 1;
        for (int k = 0; k < 40 && settled !== 1'b1; k++) begin
            step(1'b1, (k % 2) == 1, 1'b1);
            if (settled !== 1'b1) n++;
        end
        chk("ce_len", n, 2 * SC);
        step(1'b1, 1'b1, 1'b0);
        n = 0;
        wait_settled(1'b0, n);

        // Reset pulse at counter=2 in ON_SETTLE: no residual dwell afterwards.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("mid_rst", {29'd0, drive_out, drive_outn, settled}, 32'b011);
        repeat (8) begin
            step(1'b1, 1'b1, 1'b0);
            chk("no_late", {30'd0, drive_out, settled}, 32'b01);
        end
        step(1'b1, 1'b1, 1'b1);
        chk("post_rst_req", {31'd0, drive_out}, 32'd1);

        // Random traffic against the scoreboard.
        repeat (300)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

        // Default-count instance with req held high.
        @(negedge aclk);
        b_aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("big_rst", {29'd0, b_drive_out, b_drive_outn, b_settled}, 32'b011);
        @(negedge aclk);
        b_aresetn = 1'b1;
        b_req     = 1'b1;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge aclk);
            #1;
            inv_ok = (b_drive_outn === ~b_drive_out);
            chk("big_inv", {31'd0, inv_ok}, 32'd1);
            if (b_settled === 1'b1) break;
            n++;
        end
        chk("big_len", n, SCB);
        chk("big_drive", {31'd0, b_drive_out}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
